// File: rtl/stall_valid_pipeline.sv
// Elastic register pipeline: STAGES payload registers with per-stage valid bits.
// Stages advance independently so bubbles collapse while the output is stalled.
module stall_valid_pipeline #(
    parameter int STAGES = 7,
    parameter int WIDTH  = 16,
    parameter int CW     = 3
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CW-1:0]    occupancy
);

    // Handshake: a beat moves on a rising edge exactly when valid and ready are
    // both high in the cycle before it; valid never waits on ready, and a
    // flush cycle transfers nothing in either direction.

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_next;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] low_mask;
    logic [WIDTH-1:0]  d [STAGES];
    logic [CW-1:0]     occ_next;

    // Stage i may advance when any stage from i up to the output is empty, or
    // the output drains; this closed form avoids a chained combinational loop.
    always_comb begin
        adv      = '0;
        low_mask = '0;
        for (int i = 0; i < STAGES; i++) begin
            adv[i]      = out_ready | ~(&(v | low_mask));
            low_mask[i] = 1'b1;
        end
    end

    always_comb begin
        v_next    = v;
        v_next[0] = adv[0] ? in_valid : v[0];
        for (int i = 1; i < STAGES; i++) begin
            if (adv[i]) begin
                v_next[i] = v[i-1];
            end
        end
    end

    always_comb begin
        occ_next = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_next = occ_next + CW'(v_next[i]);
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = v[STAGES-1] & ~flush;
    assign out_data  = d[STAGES-1];

    // Payload only moves behind a valid bit, so empty stages keep stale data.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            v         <= '0;
            occupancy <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d[i] <= '0;
            end
        end else if (flush) begin
            v         <= '0;
            occupancy <= '0;
        end else begin
            v         <= v_next;
            occupancy <= occ_next;
            if (adv[0] && in_valid) begin
                d[0] <= in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i] && v[i-1]) begin
                    d[i] <= d[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_stall_valid_pipeline.sv
// Bench for stall_valid_pipeline: directed scenarios plus random traffic
// against a queue-of-entries model that tracks each entry's stage position.
module tb_stall_valid_pipeline;

    localparam int S  = 7;
    localparam int W  = 16;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          aclr;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          flush;
    logic [CW-1:0] occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: entries in order (front = oldest) with their current stage index.
    logic [W-1:0] exp_q[$];
    int           pos_q[$];

    always #5 clk = ~clk;

    stall_valid_pipeline #(.STAGES(S), .WIDTH(W), .CW(CW)) dut (
        .clk       (clk),
        .aclr      (aclr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (occupancy)
    );

    function automatic bit m_out_valid();
        if (flush || exp_q.size() == 0) return 1'b0;
        return pos_q[0] == S - 1;
    endfunction

    // A free slot anywhere lets a new entry in, as does a draining output.
    function automatic bit m_in_ready();
        return !flush && (exp_q.size() < S || out_ready);
    endfunction

    function automatic logic [CW-1:0] m_occ();
        return CW'(exp_q.size());
    endfunction

    task automatic model_clear();
        exp_q.delete();
        pos_q.delete();
    endtask

    task automatic apply(input bit iv, input logic [W-1:0] id, input bit ordy, input bit fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    // Update the model for the coming edge, then move to the next falling edge.
    task automatic advance();
        bit in_x;
        bit out_x;
        int ahead;
        int np;
        in_x  = in_valid && m_in_ready();
        out_x = m_out_valid() && out_ready;
        if (flush) begin
            model_clear();
        end else begin
            if (out_x) begin
                void'(exp_q.pop_front());
                void'(pos_q.pop_front());
            end
            ahead = S;
            foreach (pos_q[k]) begin
                if (pos_q[k] == S - 1)          np = pos_q[k];
                else if (pos_q[k] + 1 == ahead) np = pos_q[k];
                else                            np = pos_q[k] + 1;
                pos_q[k] = np;
                ahead    = np;
            end
            if (in_x) begin
                exp_q.push_back(in_data);
                pos_q.push_back(0);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        aclr = 1'b1;
        apply(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h expected 0000", out_data); end
        n_tests++; if (occupancy !== '0) begin n_fail++; $display("FAIL reset_occupancy got %0d expected 0", occupancy); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        flush = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_flush_in_ready got %b expected 0", in_ready); end
        flush = 1'b0;
        @(negedge clk);
        aclr = 1'b0;
        model_clear();
    endtask

    task automatic test_single();
        int first = -1;
        int cnt   = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 0) apply(1'b1, 16'h00A5, 1'b1, 1'b0);
            else        apply(1'b0, '0, 1'b1, 1'b0);
            if (c == 0) begin
                n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready got %b expected 1", in_ready); end
            end
            if (out_valid === 1'b1) begin
                cnt++;
                if (first < 0) first = c;
                n_tests++; if (out_data !== 16'h00A5) begin n_fail++; $display("FAIL single_data got %h expected 00a5", out_data); end
            end
            advance();
        end
        n_tests++; if (first != 7) begin n_fail++; $display("FAIL single_latency got %0d expected 7", first); end
        n_tests++; if (cnt != 1) begin n_fail++; $display("FAIL single_count got %0d expected 1", cnt); end
    endtask

    task automatic test_stream();
        int nxt  = 1;
        int peak = 0;
        for (int c = 0; c < 32; c++) begin
            if (c < 20) apply(1'b1, W'(c + 1), 1'b1, 1'b0);
            else        apply(1'b0, '0, 1'b1, 1'b0);
            if (c < 20) begin
                n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cycle %0d got %b expected 1", c, in_ready); end
            end
            if (int'(occupancy) > peak) peak = int'(occupancy);
            if (out_valid === 1'b1) begin
                n_tests++; if (out_data !== W'(nxt)) begin n_fail++; $display("FAIL stream_data got %0d expected %0d", out_data, nxt); end
                n_tests++; if (c != 6 + nxt) begin n_fail++; $display("FAIL stream_timing entry %0d got cycle %0d expected %0d", nxt, c, 6 + nxt); end
                nxt++;
            end
            advance();
        end
        n_tests++; if (nxt != 21) begin n_fail++; $display("FAIL stream_count got %0d expected 20", nxt - 1); end
        n_tests++; if (peak != 7) begin n_fail++; $display("FAIL stream_peak got %0d expected 7", peak); end
    endtask

    task automatic test_backpressure();
        int acc     = 0;
        int outs    = 0;
        int nxt_out = 100;
        for (int c = 0; c < 10; c++) begin
            apply(1'b1, W'(100 + acc), 1'b0, 1'b0);
            n_tests++; if (in_ready !== m_in_ready()) begin n_fail++; $display("FAIL bp_fill_in_ready cycle %0d got %b expected %b", c, in_ready, m_in_ready()); end
            if (in_ready === 1'b1) acc++;
            advance();
        end
        apply(1'b1, W'(100 + acc), 1'b0, 1'b0);
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got %b expected 0", in_ready); end
        n_tests++; if (occupancy !== CW'(7)) begin n_fail++; $display("FAIL bp_full_occupancy got %0d expected 7", occupancy); end
        n_tests++; if (acc != 7) begin n_fail++; $display("FAIL bp_accepts got %0d expected 7", acc); end
        advance();
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, W'(100 + acc), 1'b1, 1'b0);
            if (in_ready === 1'b1) acc++;
            if (out_valid === 1'b1) begin
                outs++;
                n_tests++; if (out_data !== W'(nxt_out)) begin n_fail++; $display("FAIL bp_release_data got %0d expected %0d", out_data, nxt_out); end
                nxt_out++;
            end
            advance();
        end
        n_tests++; if (outs != 3) begin n_fail++; $display("FAIL bp_release_outputs got %0d expected 3", outs); end
        n_tests++; if (acc != 10) begin n_fail++; $display("FAIL bp_release_accepts got %0d expected 10", acc); end
        for (int c = 0; c < 12; c++) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            if (out_valid === 1'b1) begin
                n_tests++; if (out_data !== W'(nxt_out)) begin n_fail++; $display("FAIL bp_drain_data got %0d expected %0d", out_data, nxt_out); end
                nxt_out++;
            end
            advance();
        end
        n_tests++; if (nxt_out != 110) begin n_fail++; $display("FAIL bp_drain_count got %0d expected 110", nxt_out); end
    endtask

    task automatic test_bubble_collapse();
        for (int c = 0; c < 12; c++) begin
            apply((c % 3 == 0) && (c <= 6), W'(16'h0B01 + c / 3), 1'b0, 1'b0);
            advance();
        end
        for (int r = 0; r < 4; r++) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            if (r == 0) begin
                n_tests++; if (occupancy !== CW'(3)) begin n_fail++; $display("FAIL bubble_occupancy got %0d expected 3", occupancy); end
            end
            if (r < 3) begin
                n_tests++; if (out_valid !== 1'b1 || out_data !== W'(16'h0B01 + r)) begin
                    n_fail++; $display("FAIL bubble_release_%0d got valid %b data %h expected valid 1 data %h", r, out_valid, out_data, W'(16'h0B01 + r));
                end
            end else begin
                n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_after got %b expected 0", out_valid); end
            end
            advance();
        end
    endtask

    task automatic test_flush();
        int leaked = 0;
        for (int c = 0; c < 7; c++) begin
            apply(c < 5, W'(16'hF000 + c), 1'b0, 1'b0);
            advance();
        end
        apply(1'b1, 16'hF0FF, 1'b1, 1'b1);
        n_tests++; if (occupancy !== CW'(5)) begin n_fail++; $display("FAIL flush_pre_occupancy got %0d expected 5", occupancy); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b expected 0", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b expected 0", out_valid); end
        advance();
        for (int c = 0; c < 15; c++) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            if (c == 0) begin
                n_tests++; if (occupancy !== '0) begin n_fail++; $display("FAIL flush_post_occupancy got %0d expected 0", occupancy); end
            end
            if (out_valid === 1'b1) leaked++;
            advance();
        end
        n_tests++; if (leaked != 0) begin n_fail++; $display("FAIL flush_leak got %0d outputs expected 0", leaked); end
    endtask

    task automatic test_async_reset();
        int nxt = 0;
        for (int c = 0; c < 8; c++) begin
            apply(c < 4, W'(16'hC000 + c), 1'b0, 1'b0);
            advance();
        end
        apply(1'b0, '0, 1'b0, 1'b0);
        n_tests++; if (out_valid !== 1'b1 || occupancy !== CW'(4)) begin
            n_fail++; $display("FAIL areset_pre got valid %b occupancy %0d expected valid 1 occupancy 4", out_valid, occupancy);
        end
        #1 aclr = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid got %b expected 0", out_valid); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL areset_out_data got %h expected 0000", out_data); end
        n_tests++; if (occupancy !== '0) begin n_fail++; $display("FAIL areset_occupancy got %0d expected 0", occupancy); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready got %b expected 1", in_ready); end
        #1 aclr = 1'b0;
        model_clear();
        advance();
        for (int c = 0; c < 14; c++) begin
            if (c < 3) apply(1'b1, W'(16'h0D00 + c), 1'b1, 1'b0);
            else       apply(1'b0, '0, 1'b1, 1'b0);
            if (out_valid === 1'b1) begin
                n_tests++; if (out_data !== W'(16'h0D00 + nxt) || c != 7 + nxt) begin
                    n_fail++; $display("FAIL areset_resume got data %h cycle %0d expected %h cycle %0d", out_data, c, W'(16'h0D00 + nxt), 7 + nxt);
                end
                nxt++;
            end
            advance();
        end
        n_tests++; if (nxt != 3) begin n_fail++; $display("FAIL areset_resume_count got %0d expected 3", nxt); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            apply($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
            n_tests++; if (in_ready !== m_in_ready()) begin n_fail++; $display("FAIL rand_in_ready cycle %0d got %b expected %b", c, in_ready, m_in_ready()); end
            n_tests++; if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL rand_out_valid cycle %0d got %b expected %b", c, out_valid, m_out_valid()); end
            if (m_out_valid()) begin
                n_tests++; if (out_data !== exp_q[0]) begin n_fail++; $display("FAIL rand_out_data cycle %0d got %h expected %h", c, out_data, exp_q[0]); end
            end
            n_tests++; if (occupancy !== m_occ()) begin n_fail++; $display("FAIL rand_occupancy cycle %0d got %0d expected %0d", c, occupancy, m_occ()); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_bubble_collapse();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
